dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory access port (`ram_data`) between the CPU load/store stage (port 0) and a secondary master (port 1: debug/loader/DMA). Each cycle it selects at most one request and forwards it as a `ram_ctrl`/`addr`/`wr_data` triple. Port 0 has fixed priority, and a starvation counter guarantees port 1 progress. The block tags every issued read and returns the one-cycle-late read data to the master that issued it.

---
 rtl/dmem_arbiter_if.sv | 42 ++++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two master ports and the data-memory port of dmem_arbiter.
// The arbiter connects through the slave modport; masters and memory sit on master.
interface dmem_arbiter_if;
  logic        m0_req;
  logic [4:0]  m0_ctrl;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [4:0]  m1_ctrl;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;

  logic [4:0]  ram_ctrl;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport slave (
    input  m0_req, m0_ctrl, m0_addr, m0_wdata,
    input  m1_req, m1_ctrl, m1_addr, m1_wdata,
    input  ram_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output ram_ctrl, ram_addr, ram_wdata
  );

  modport master (
    output m0_req, m0_ctrl, m0_addr, m0_wdata,
    output m1_req, m1_ctrl, m1_addr, m1_wdata,
    output ram_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  ram_ctrl, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the CPU (port 0, fixed priority) and a
// secondary master (port 1, protected by a starvation counter). Reads are
// tagged with their issuing port so the one-cycle-late data goes back to it.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_M0,
    SEL_M1
  } sel_e;

  sel_e        sel;
  logic [7:0]  starve_cnt_q, starve_cnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_owner_q, rd_owner_d;
  logic [4:0]  sel_ctrl;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // The request enable bit is regenerated here, so the masters' copy is dropped.
  logic unused_ctrl_en;
  assign unused_ctrl_en = bus.m0_ctrl[0] ^ bus.m1_ctrl[0];

  // Arbitration: starved port 1 first, then port 0, then port 1; nothing in reset.
  always_comb begin
    sel = SEL_NONE;
    if (rst_n) begin
      if (bus.m1_req && (starve_cnt_q == LIMIT)) begin
        sel = SEL_M1;
      end else if (bus.m0_req) begin
        sel = SEL_M0;
      end else if (bus.m1_req) begin
        sel = SEL_M1;
      end
    end
  end

  // Route the winning request to memory and raise its grant.
  always_comb begin
    sel_ctrl   = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    bus.m0_gnt = 1'b0;
    bus.m1_gnt = 1'b0;
    case (sel)
      SEL_M0: begin
        sel_ctrl   = {bus.m0_ctrl[4:1], 1'b1};
        sel_addr   = bus.m0_addr;
        sel_wdata  = bus.m0_wdata;
        bus.m0_gnt = 1'b1;
      end
      SEL_M1: begin
        sel_ctrl   = {bus.m1_ctrl[4:1], 1'b1};
        sel_addr   = bus.m1_addr;
        sel_wdata  = bus.m1_wdata;
        bus.m1_gnt = 1'b1;
      end
      default: ;
    endcase
    bus.ram_ctrl  = sel_ctrl;
    bus.ram_addr  = sel_addr;
    bus.ram_wdata = sel_wdata;
  end

  // Next state: starvation count saturates at the limit, reads get tagged.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.m1_req || (sel == SEL_M1)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 8'd1;
    end
    rd_pend_d  = (sel != SEL_NONE) && !sel_ctrl[1];
    rd_owner_d = (sel == SEL_M1);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Return read data only to the port that issued the read.
  always_comb begin
    bus.m0_rvalid = rd_pend_q && !rd_owner_q;
    bus.m1_rvalid = rd_pend_q && rd_owner_q;
    bus.m0_rdata  = bus.m0_rvalid ? bus.ram_rdata : '0;
    bus.m1_rdata  = bus.m1_rvalid ? bus.ram_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for the
// multi-cycle cases and a random phase, all checked against a transaction
// level model (winner rule, denied-cycle count, pending-read queue entry).
module tb_dmem_arbiter;

  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- memory helpers ----------------
  function automatic logic [7:0] init_byte(input int i);
    case (i)
      16: return 8'hEF;
      17: return 8'hBE;
      18: return 8'hAD;
      19: return 8'hDE;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  function automatic logic [31:0] ld(input logic [7:0] m [64], input logic [31:0] addr,
                                     input logic [2:0] f3);
    int b;
    logic [31:0] w;
    b = int'(addr[5:0]);
    w = {m[(b + 3) % 64], m[(b + 2) % 64], m[(b + 1) % 64], m[b]};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] bmask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Data memory environment: read data appears the cycle after the read.
  logic [7:0] mem_env [64];
  bit         mem_loaded;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem_env[i] <= init_byte(i);
      mem_loaded <= 1'b1;
    end else if (bus.ram_ctrl[0]) begin
      if (bus.ram_ctrl[1]) begin
        for (int k = 0; k < 4; k++)
          if (bmask(bus.ram_ctrl[4:2])[k])
            mem_env[(int'(bus.ram_addr[5:0]) + k) % 64] <= bus.ram_wdata[8*k +: 8];
      end else begin
        bus.ram_rdata <= ld(mem_env, bus.ram_addr, bus.ram_ctrl[4:2]);
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  mem_ref [64];
  int          starve;      // consecutive cycles port 1 has been waiting
  int          pend_port;   // port owed a response next cycle, -1 if none
  logic [31:0] pend_data;
  int          last_w;

  function automatic int winner();
    if (bus.m1_req && starve >= LIMIT) return 1;
    if (bus.m0_req) return 0;
    if (bus.m1_req) return 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare all outputs against the model, away from the active edge.
  task automatic sample();
    int w;
    logic [4:0]  c;
    logic [31:0] a, d;
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_gnt0", 32'(bus.m0_gnt), 0);
      chk("rst_gnt1", 32'(bus.m1_gnt), 0);
      chk("rst_ram_ctrl", 32'(bus.ram_ctrl), 0);
      chk("rst_ram_addr", bus.ram_addr, 0);
      chk("rst_ram_wdata", bus.ram_wdata, 0);
      chk("rst_rvalid0", 32'(bus.m0_rvalid), 0);
      chk("rst_rvalid1", 32'(bus.m1_rvalid), 0);
      chk("rst_rdata0", bus.m0_rdata, 0);
      chk("rst_rdata1", bus.m1_rdata, 0);
    end else begin
      w = winner();
      c = '0; a = '0; d = '0;
      if (w == 0) begin c = {bus.m0_ctrl[4:1], 1'b1}; a = bus.m0_addr; d = bus.m0_wdata; end
      if (w == 1) begin c = {bus.m1_ctrl[4:1], 1'b1}; a = bus.m1_addr; d = bus.m1_wdata; end
      chk("gnt0", 32'(bus.m0_gnt), 32'(w == 0));
      chk("gnt1", 32'(bus.m1_gnt), 32'(w == 1));
      chk("ram_ctrl", 32'(bus.ram_ctrl), 32'(c));
      chk("ram_addr", bus.ram_addr, a);
      chk("ram_wdata", bus.ram_wdata, d);
      chk("rvalid0", 32'(bus.m0_rvalid), 32'(pend_port == 0));
      chk("rvalid1", 32'(bus.m1_rvalid), 32'(pend_port == 1));
      chk("rdata0", bus.m0_rdata, (pend_port == 0) ? pend_data : 32'd0);
      chk("rdata1", bus.m1_rdata, (pend_port == 1) ? pend_data : 32'd0);
    end
  endtask

  // Apply the accepted transaction to the model, then cross the clock edge.
  task automatic advance();
    int w;
    logic [4:0]  c;
    logic [31:0] a, d;
    if (!rst_n) begin
      starve = 0; pend_port = -1; last_w = -1;
    end else begin
      w = winner();
      last_w = w;
      if (!bus.m1_req || w == 1) starve = 0;
      else starve++;
      pend_port = -1;
      if (w >= 0) begin
        c = (w == 0) ? bus.m0_ctrl : bus.m1_ctrl;
        a = (w == 0) ? bus.m0_addr : bus.m1_addr;
        d = (w == 0) ? bus.m0_wdata : bus.m1_wdata;
        if (c[1]) begin
          for (int k = 0; k < 4; k++)
            if (bmask(c[4:2])[k]) mem_ref[(int'(a[5:0]) + k) % 64] = d[8*k +: 8];
        end else begin
          pend_port = w;
          pend_data = ld(mem_ref, a, c[4:2]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic set0(input logic r, input logic [4:0] c, input logic [31:0] a, input logic [31:0] d);
    bus.m0_req = r; bus.m0_ctrl = c; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set1(input logic r, input logic [4:0] c, input logic [31:0] a, input logic [31:0] d);
    bus.m1_req = r; bus.m1_ctrl = c; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  typedef struct {
    logic        m0_req;
    logic [4:0]  m0_ctrl;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_req;
    logic [4:0]  m1_ctrl;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        eg0;
    logic        eg1;
    logic [4:0]  ectrl;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) mem_ref[i] = init_byte(i);
    starve = 0; pend_port = -1; pend_data = '0; last_w = -1;

    vt[0] = '{1'b0, 5'b00000, 32'h00, 32'h0,        1'b0, 5'b00000, 32'h00, 32'h0,  1'b0, 1'b0, 5'b00000, 32'h00};
    vt[1] = '{1'b1, 5'b01000, 32'h10, 32'h0,        1'b0, 5'b00000, 32'h00, 32'h0,  1'b1, 1'b0, 5'b01001, 32'h10};
    vt[2] = '{1'b0, 5'b00000, 32'h00, 32'h0,        1'b1, 5'b00010, 32'h07, 32'hA5, 1'b0, 1'b1, 5'b00011, 32'h07};
    vt[3] = '{1'b1, 5'b01001, 32'h20, 32'h0,        1'b1, 5'b00000, 32'h30, 32'h0,  1'b1, 1'b0, 5'b01001, 32'h20};
    vt[4] = '{1'b0, 5'b00000, 32'h00, 32'h0,        1'b1, 5'b10100, 32'h3C, 32'h0,  1'b0, 1'b1, 5'b10101, 32'h3C};
    vt[5] = '{1'b1, 5'b01011, 32'h08, 32'h12345678, 1'b0, 5'b00000, 32'h00, 32'h0,  1'b1, 1'b0, 5'b01011, 32'h08};
    vt[6] = '{1'b1, 5'b01100, 32'h04, 32'h0,        1'b0, 5'b00000, 32'h00, 32'h0,  1'b1, 1'b0, 5'b01101, 32'h04};
    vt[7] = '{1'b1, 5'b10000, 32'h11, 32'h0,        1'b1, 5'b00110, 32'h01, 32'h0,  1'b1, 1'b0, 5'b10001, 32'h11};

    // Reset with both ports requesting, then first grant goes to port 0.
    rst_n = 1'b0;
    set0(1'b1, 5'b01000, 32'h10, 32'h0);
    set1(1'b1, 5'b01000, 32'h20, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    sample();
    chk("first_gnt0", 32'(bus.m0_gnt), 1);
    chk("single_rd_ctrl", 32'(bus.ram_ctrl), 32'b01001);
    advance();
    set0(1'b0, 5'b0, 32'h0, 32'h0);
    set1(1'b0, 5'b0, 32'h0, 32'h0);
    sample();
    chk("single_rd_rvalid0", 32'(bus.m0_rvalid), 1);
    chk("single_rd_rdata0", bus.m0_rdata, 32'hDEADBEEF);
    chk("single_rd_rvalid1", 32'(bus.m1_rvalid), 0);
    advance();

    // Interleaved responses to the two ports.
    set0(1'b1, 5'b01000, 32'h0, 32'h0);
    sample();
    chk("il_gnt0", 32'(bus.m0_gnt), 1);
    advance();
    set0(1'b0, 5'b0, 32'h0, 32'h0);
    set1(1'b1, 5'b01000, 32'h4, 32'h0);
    sample();
    chk("il_gnt1", 32'(bus.m1_gnt), 1);
    chk("il_rvalid0", 32'(bus.m0_rvalid), 1);
    chk("il_rdata0", bus.m0_rdata, 32'h7A55300B);
    chk("il_rdata1_idle", bus.m1_rdata, 0);
    advance();
    set1(1'b0, 5'b0, 32'h0, 32'h0);
    sample();
    chk("il_rvalid1", 32'(bus.m1_rvalid), 1);
    chk("il_rdata1", bus.m1_rdata, 32'h0EE9C49F);
    chk("il_rvalid0_idle", 32'(bus.m0_rvalid), 0);
    chk("il_rdata0_idle", bus.m0_rdata, 0);
    advance();

    // Byte store by port 1 then signed byte load by port 0.
    set1(1'b1, 5'b00010, 32'h7, 32'h000000A5);
    step();
    set1(1'b0, 5'b0, 32'h0, 32'h0);
    set0(1'b1, 5'b00000, 32'h7, 32'h0);
    sample();
    chk("wr_no_rvalid0", 32'(bus.m0_rvalid), 0);
    chk("wr_no_rvalid1", 32'(bus.m1_rvalid), 0);
    advance();
    set0(1'b0, 5'b0, 32'h0, 32'h0);
    sample();
    chk("wr_rd_rvalid0", 32'(bus.m0_rvalid), 1);
    chk("wr_rd_rdata0", bus.m0_rdata, 32'hFFFFFFA5);
    advance();

    // Starvation: both requesting for 20 cycles.
    set0(1'b1, 5'b01010, 32'h30, 32'h11223344);
    set1(1'b1, 5'b01000, 32'h3C, 32'h0);
    for (int i = 0; i < 20; i++) begin
      sample();
      chk($sformatf("starve_gnt1_c%0d", i), 32'(bus.m1_gnt), 32'(i == 8 || i == 17));
      chk($sformatf("starve_gnt0_c%0d", i), 32'(bus.m0_gnt), 32'(!(i == 8 || i == 17)));
      chk($sformatf("starve_onehot_c%0d", i), 32'(bus.m0_gnt & bus.m1_gnt), 0);
      advance();
    end
    set0(1'b0, 5'b0, 32'h0, 32'h0);
    set1(1'b0, 5'b0, 32'h0, 32'h0);
    step();

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      set0(vt[i].m0_req, vt[i].m0_ctrl, vt[i].m0_addr, vt[i].m0_wdata);
      set1(vt[i].m1_req, vt[i].m1_ctrl, vt[i].m1_addr, vt[i].m1_wdata);
      sample();
      chk($sformatf("vec%0d_gnt0", i), 32'(bus.m0_gnt), 32'(vt[i].eg0));
      chk($sformatf("vec%0d_gnt1", i), 32'(bus.m1_gnt), 32'(vt[i].eg1));
      chk($sformatf("vec%0d_ram_ctrl", i), 32'(bus.ram_ctrl), 32'(vt[i].ectrl));
      chk($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vt[i].eaddr);
      advance();
    end
    set0(1'b0, 5'b0, 32'h0, 32'h0);
    set1(1'b0, 5'b0, 32'h0, 32'h0);
    step();

    // Reset while a read is in flight, with port 1 partly starved.
    set0(1'b1, 5'b01010, 32'h28, 32'hCAFEF00D);
    set1(1'b1, 5'b01000, 32'h2C, 32'h0);
    repeat (5) step();
    set0(1'b1, 5'b01000, 32'h10, 32'h0);
    sample();
    chk("mid_rd_gnt0", 32'(bus.m0_gnt), 1);
    #2 rst_n = 1'b0;
    advance();
    sample();
    chk("mid_rd_rvalid0_rst", 32'(bus.m0_rvalid), 0);
    advance();
    rst_n = 1'b1;
    set0(1'b1, 5'b01010, 32'h28, 32'hCAFEF00D);
    for (int i = 0; i < 10; i++) begin
      sample();
      if (i == 0) chk("mid_rd_rvalid0_after", 32'(bus.m0_rvalid), 0);
      chk($sformatf("post_rst_gnt1_c%0d", i), 32'(bus.m1_gnt), 32'(i == 8));
      advance();
    end

    // Random traffic; a master holds its request until granted.
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      if (last_w == 0 || !bus.m0_req)
        set0(1'($urandom_range(0, 3) != 0), 5'($urandom), 32'($urandom_range(0, 63)), $urandom);
      if (last_w == 1 || !bus.m1_req)
        set1(1'($urandom_range(0, 2) != 0), 5'($urandom), 32'($urandom_range(0, 63)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
